// File: rtl/ram256_wb_ctrl.sv
// ram256_wb_ctrl: Wishbone classic slave sequencing single-port RAM256 accesses with registered read data
module ram256_wb_ctrl #(
  parameter int          WSIZE    = 4,
  parameter int          AW       = 8,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          READ_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WSIZE-1:0]   wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [WSIZE*8-1:0] wb_dat_i,
  output logic               wb_ack_o,
  output logic [WSIZE*8-1:0] wb_dat_o,
  output logic               EN0,
  output logic [WSIZE-1:0]   WE0,
  output logic [AW-1:0]      A0,
  output logic [WSIZE*8-1:0] Di0,
  input  logic [WSIZE*8-1:0] Do0
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;
  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic rd, rd_n, en_n, req, hit;
  logic [WSIZE-1:0] we_n;
  logic [AW-1:0] a_n;
  logic [WSIZE*8-1:0] di_n, dat_n;
  logic unused_ok;
  assign unused_ok = &{1'b0, wb_adr_i[1:0]};
  assign req = wb_cyc_i & wb_stb_i;
  assign hit = wb_adr_i[31:AW+2] == BASE_ADR[31:AW+2];
  assign wb_ack_o = state == ACK;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rd_n = rd;
    en_n = 1'b0;
    we_n = '0;
    a_n = A0;
    di_n = Di0;
    dat_n = wb_dat_o;
    case (state)
      IDLE: if (req) begin
        rd_n = !wb_we_i;
        if (hit) begin
          en_n = 1'b1;
          we_n = wb_we_i ? wb_sel_i : '0;
          a_n = wb_adr_i[AW+1:2];
          di_n = wb_dat_i;
          state_n = ACCESS;
        end else begin
          dat_n = wb_we_i ? wb_dat_o : '0;
          state_n = ACK;
        end
      end
      ACCESS: begin
        cnt_n = CNT_INIT;
        if (!wb_cyc_i) state_n = IDLE;
        else if (rd) state_n = RDWAIT;
        else state_n = ACK;
      end
      RDWAIT: begin
        // a dropped cycle abandons the wait; the RAM finishes on its own
        if (!wb_cyc_i) state_n = IDLE;
        else if (cnt != 2'd0) cnt_n = cnt - 2'd1;
        else begin
          dat_n = Do0;
          state_n = ACK;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      rd <= 1'b0;
      EN0 <= 1'b0;
      WE0 <= '0;
      A0 <= '0;
      Di0 <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd <= rd_n;
      EN0 <= en_n;
      WE0 <= we_n;
      A0 <= a_n;
      Di0 <= di_n;
      wb_dat_o <= dat_n;
    end
  end
endmodule

// File: tb/tb_ram256_wb_ctrl.sv
// tb_ram256_wb_ctrl: three controller instances (READ_LAT 1, READ_LAT 3, remote base) against a timeline model
module tb_ram256_wb_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic cyc [3], stb [3], we [3], ack [3], en0 [3];
  logic [3:0] sel [3], we0 [3];
  logic [31:0] adr [3], wdat [3], rdat [3], di0 [3], do0 [3];
  logic [7:0] a0 [3];
  int n_chk = 0;
  int n_fail = 0;

  function automatic int lat(input int i);
    return i == 1 ? 3 : 1;
  endfunction
  function automatic logic [31:0] base(input int i);
    return i == 2 ? 32'h3000_0000 : 32'h0000_0000;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gd
    ram256_wb_ctrl #(.READ_LAT(g == 1 ? 3 : 1), .BASE_ADR(g == 2 ? 32'h3000_0000 : 32'h0)) u (
      .CLK(CLK), .RST(RST), .wb_cyc_i(cyc[g]), .wb_stb_i(stb[g]), .wb_we_i(we[g]),
      .wb_sel_i(sel[g]), .wb_adr_i(adr[g]), .wb_dat_i(wdat[g]), .wb_ack_o(ack[g]),
      .wb_dat_o(rdat[g]), .EN0(en0[g]), .WE0(we0[g]), .A0(a0[g]), .Di0(di0[g]), .Do0(do0[g]));
  end

  // RAM macro model: samples on the edge, read data emerges READ_LAT edges later
  logic [31:0] rmem [3][256];
  logic [31:0] pipe [3][3];
  always @(posedge CLK)
    for (int i = 0; i < 3; i++) begin
      if (en0[i])
        for (int b = 0; b < 4; b++)
          if (we0[i][b]) rmem[i][a0[i]][b*8+:8] <= di0[i][b*8+:8];
      pipe[i][0] <= en0[i] ? rmem[i][a0[i]] : 32'hA5A5_5A5A;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  always_comb
    for (int i = 0; i < 3; i++) do0[i] = pipe[i][lat(i)-1];

  logic s_rst;
  logic s_cyc [3], s_stb [3], s_we [3];
  logic [3:0] s_sel [3];
  logic [31:0] s_adr [3], s_dat [3];
  always @(posedge CLK) begin
    s_rst <= RST;
    for (int i = 0; i < 3; i++) begin
      s_cyc[i] <= cyc[i];
      s_stb[i] <= stb[i];
      s_we[i] <= we[i];
      s_sel[i] <= sel[i];
      s_adr[i] <= adr[i];
      s_dat[i] <= wdat[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Timeline model: ph counts edges since the sampling edge, a is the edge after which ack shows
  int ph [3] = '{-1, -1, -1};
  int a [3];
  bit inr [3], rd [3];
  logic e_en [3], e_ack [3];
  logic [3:0] e_we [3];
  logic [7:0] e_a0 [3];
  logic [31:0] e_di [3], e_dat [3], bs;
  logic [31:0] emem [3][256];
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        e_en[i] = 1'b0;
        e_we[i] = 4'h0;
        e_ack[i] = 1'b0;
        if (s_rst) begin
          ph[i] = -1;
          e_a0[i] = 8'h0;
          e_di[i] = 32'h0;
          e_dat[i] = 32'h0;
        end else if (ph[i] < 0) begin
          if (s_cyc[i] && s_stb[i]) begin
            bs = base(i);
            inr[i] = s_adr[i][31:10] == bs[31:10];
            rd[i] = !s_we[i];
            ph[i] = 0;
            a[i] = !inr[i] ? 0 : rd[i] ? 1 + lat(i) : 1;
            if (inr[i]) begin
              e_en[i] = 1'b1;
              e_we[i] = s_we[i] ? s_sel[i] : 4'h0;
              e_a0[i] = s_adr[i][9:2];
              e_di[i] = s_dat[i];
              if (s_we[i])
                for (int b = 0; b < 4; b++)
                  if (s_sel[i][b]) emem[i][s_adr[i][9:2]][b*8+:8] = s_dat[i][b*8+:8];
            end else begin
              e_ack[i] = 1'b1;
              if (rd[i]) e_dat[i] = 32'h0;
            end
          end
        end else begin
          ph[i]++;
          if (inr[i] && ph[i] <= a[i] && !s_cyc[i]) ph[i] = -1;
          else if (ph[i] == a[i]) begin
            e_ack[i] = 1'b1;
            if (rd[i]) e_dat[i] = emem[i][e_a0[i]];
          end else if (ph[i] > a[i]) ph[i] = -1;
        end
        chk($sformatf("ack%0d", i), 32'(ack[i]), 32'(e_ack[i]));
        chk($sformatf("en0_%0d", i), 32'(en0[i]), 32'(e_en[i]));
        chk($sformatf("we0_%0d", i), 32'(we0[i]), 32'(e_we[i]));
        chk($sformatf("a0_%0d", i), 32'(a0[i]), 32'(e_a0[i]));
        chk($sformatf("di0_%0d", i), di0[i], e_di[i]);
        chk($sformatf("dat_o%0d", i), rdat[i], e_dat[i]);
      end
    end
  end

  task automatic req(input int i, input logic w, input logic [3:0] s, input logic [31:0] ad, input logic [31:0] d);
    cyc[i] = 1'b1;
    stb[i] = 1'b1;
    we[i] = w;
    sel[i] = s;
    adr[i] = ad;
    wdat[i] = d;
  endtask

  task automatic wait_ack(input int i, input bit hold, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!ack[i] && n < 12);
    if (!ack[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout%0d: no ack after %0d cycles", i, n);
    end
    if (!hold) begin
      cyc[i] = 1'b0;
      stb[i] = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic xfer(input int i, input logic w, input logic [3:0] s, input logic [31:0] ad,
                      input logic [31:0] d, input bit hold, input int exp_n, input string nm);
    int n;
    req(i, w, s, ad, d);
    wait_ack(i, hold, n);
    chk({nm, "_lat"}, n, exp_n);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0;
      stb[i] = 1'b0;
      we[i] = 1'b0;
      sel[i] = 4'h0;
      adr[i] = 32'h0;
      wdat[i] = 32'h0;
    end
    req(0, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    wait_ack(0, 1'b0, n);
    chk("rst_lat", n, 2);

    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 2, "wr");
    chk("wr_a0", 32'(a0[0]), 32'h04);
    chk("wr_di0", di0[0], 32'hDEAD_BEEF);
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 3, "rd1");
    chk("rd1_dat", rdat[0], 32'hDEAD_BEEF);
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 3, "rd_rst");
    chk("rd_rst_dat", rdat[0], 32'h1234_5678);
    xfer(0, 1'b1, 4'b0010, 32'h10, 32'h0000_AB00, 1'b0, 2, "bw");
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 3, "bw_rd");
    chk("bw_dat", rdat[0], 32'hDEAD_ABEF);
    xfer(0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 1'b0, 2, "sel0");
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 3, "sel0_rd");
    chk("sel0_dat", rdat[0], 32'hDEAD_ABEF);
    xfer(0, 1'b1, 4'hF, 32'h24, 32'hCAFE_F00D, 1'b1, 2, "b2b_w0");
    xfer(0, 1'b1, 4'hF, 32'h28, 32'h0102_0304, 1'b1, 3, "b2b_w1");
    xfer(0, 1'b0, 4'hF, 32'h24, 32'h0, 1'b1, 4, "b2b_r0");
    chk("b2b_r0_dat", rdat[0], 32'hCAFE_F00D);
    xfer(0, 1'b0, 4'hF, 32'h28, 32'h0, 1'b0, 4, "b2b_r1");
    chk("b2b_r1_dat", rdat[0], 32'h0102_0304);

    xfer(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 2, "l3_wr");
    xfer(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 5, "l3_rd");
    chk("l3_rd_dat", rdat[1], 32'hDEAD_BEEF);
    req(1, 1'b0, 4'hF, 32'h10, 32'h0);
    repeat (2) @(negedge CLK);
    cyc[1] = 1'b0;
    @(negedge CLK);
    chk("abort_ack", 32'(ack[1]), 32'h0);
    chk("abort_dat", rdat[1], 32'hDEAD_BEEF);
    xfer(1, 1'b1, 4'hF, 32'h30, 32'h55AA_55AA, 1'b0, 2, "post_abort_wr");
    chk("post_abort_dat", rdat[1], 32'hDEAD_BEEF);
    xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, 5, "post_abort_rd");
    chk("post_abort_rd_dat", rdat[1], 32'h55AA_55AA);

    xfer(2, 1'b1, 4'hF, 32'h3000_0040, 32'h8765_4321, 1'b0, 2, "hi_wr");
    xfer(2, 1'b0, 4'hF, 32'h3000_0040, 32'h0, 1'b0, 3, "hi_rd");
    chk("hi_rd_dat", rdat[2], 32'h8765_4321);
    xfer(2, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 1'b0, 1, "oor_rd");
    chk("oor_rd_dat", rdat[2], 32'h0);
    xfer(2, 1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 1, "oor_wr");
    chk("oor_wr_dat", rdat[2], 32'h0);
    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram256_wb_ctrl.md
# ram256_wb_ctrl

Wishbone classic slave that owns the single port of a RAM256 macro (EN0/WE0/A0/Di0/Do0) and translates bus cycles into properly timed RAM accesses. Sits between the management Wishbone interconnect and the on-chip RAM256 instance. It decodes a base address, sequences enable and byte-write strobes, waits out the RAM read latency, and returns an ack with registered read data.

## Interface
- WSIZE, 4: bytes per word; RAM data width is WSIZE*8, and RAM WE0 width is WSIZE.
- AW, 8: RAM word-address width. RAM256 is 256 words.
- BASE_ADR, 32'h0000_0000: byte base address. Only bits [31:AW+2] are compared.
- READ_LAT, 1: edges from the RAM sampling EN0 to a valid Do0. Legal range 1..3.

Ports:
- CLK  in  1  single clock for the bus and the RAM port.
- RST  in  1  reset, synchronous and active-high.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  WSIZE  byte selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  WSIZE*8  write data.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_dat_o  out  WSIZE*8  registered read data.
- EN0  out  1  RAM enable. Registered.
- WE0  out  WSIZE  RAM byte write enables. Registered.
- A0  out  AW  RAM word address (wb_adr_i[AW+1:2]). Registered.
- Di0  out  WSIZE*8  RAM write data. Registered.
- Do0  in  WSIZE*8  RAM read data.

## Operation
- Request: wb_cyc_i & wb_stb_i, sampled in IDLE only. A request is in range when wb_adr_i[31:AW+2] == BASE_ADR[31:AW+2].
- States: IDLE, ACCESS, RDWAIT, ACK.
- IDLE, on a request:
  - In range: EN0<=1; A0, Di0 <= bus values; WE0 <= wb_we_i ? wb_sel_i : 0. Next state ACCESS.
  - Out of range: no RAM access. A read latches wb_dat_o<=0. Next state ACK.
- ACCESS: EN0<=0, WE0<=0; A0 and Di0 hold. A write goes to ACK. A read loads the latency counter with READ_LAT-1 and goes to RDWAIT.
- RDWAIT: while the counter is nonzero, decrement it. When it is 0, latch wb_dat_o<=Do0 and go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. A request present on the edge that leaves ACK is not sampled; a new request is accepted from the next edge.
- Abort: if wb_cyc_i drops in ACCESS or RDWAIT, the RAM access already issued completes. No ack is given, wb_dat_o is unchanged, and the FSM returns to IDLE at the next edge.
- wb_sel_i == 0 on a write: EN0 still pulses with WE0=0 (no bytes change), and the write is acked normally.
- wb_dat_o holds its last value between reads. Writes do not modify it.

## Timing
- Reset: every output is 0 (wb_ack_o, wb_dat_o, EN0, WE0, A0, Di0), and the FSM is in IDLE. Reset mid-transaction aborts it with no ack.
- EN0 is high for exactly one cycle per in-range access.
- Edge E0 samples the request. EN0/WE0/A0/Di0 are valid from E0 until E1, and the RAM samples at E1.
- Write: wb_ack_o is high in the cycle after E1. That is 2 cycles from request to ack.
- Read: Do0 is captured at edge E(1+READ_LAT), and wb_ack_o is high in the following cycle. Request-to-ack is 2+READ_LAT cycles, i.e. 3 with the default.
- Out-of-range access: wb_ack_o is high in the cycle after E0, i.e. 1 cycle.
- Back-to-back throughput: one transaction per 3 cycles for writes and 4 cycles for reads at READ_LAT=1.
- wb_dat_o is valid throughout the cycle in which wb_ack_o=1.

## Test plan
- Reset with RST=1 held for 2 cycles while a request is present. Required: all outputs 0, no EN0 pulse, and no ack until 1 cycle after RST falls and the request is sampled.
- Write adr=0x0000_0010, dat=0xDEADBEEF, sel=4'hF. Required: one EN0 pulse with A0=0x04, WE0=4'hF, Di0=0xDEADBEEF. wb_ack_o is high in cycle 2 for one cycle.
- Read back adr=0x10, with a RAM model at READ_LAT=1 and READ_LAT=3. Required: wb_dat_o=0xDEADBEEF with ack in cycle 3 and cycle 5 respectively. WE0=0 throughout.
- Byte write: sel=4'b0010, dat=0x0000AB00 to adr=0x10, then read. Required: WE0=4'b0010 during the write, and the read returns 0xDEADABEF.
- Out-of-range read with BASE_ADR=0x3000_0000 and adr=0x0000_0000. Required: no EN0 pulse; ack in cycle 1 with wb_dat_o=0.
- Drop wb_cyc_i during RDWAIT (READ_LAT=3), then immediately issue a new write. Required: no ack for the aborted read, wb_dat_o unchanged, and the new write is acked 2 cycles after it is sampled.
